// File: rtl/alu_mdu.sv
// Integer execute unit: RV32I/RV64I register-register ALU ops plus the M-extension
// multiply/divide set (iterative, XLEN cycles) behind a valid/ready handshake.
module alu_mdu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      operation,
    input  logic            control,
    input  logic            muldiv,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            neg
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_reg, state_next;
    logic [SHW-1:0]      cnt_reg;
    logic [XLEN-1:0]     result_reg;
    logic [2:0]          op_reg;
    logic [XLEN-1:0]     opnd_reg;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   acc_reg;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic                flip_reg;
    logic                rem_neg_reg;
    logic                divz_reg;

    logic                accept;
    logic                last_iter;
    logic [SHW-1:0]      shamt;
    logic [XLEN-1:0]     alu_res;
    logic                sa, sb, a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_shift;
    logic                div_ge;
    logic [XLEN-1:0]     div_rem;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   step_next;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo_fix, rem_fix, fix_res;

    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign last_iter = (state_reg == RUN) && (cnt_reg == SHW'(XLEN - 1));
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign zero      = (result_reg == '0);
    assign neg       = result_reg[XLEN-1];
    assign shamt     = b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (operation)
            3'b000:  alu_res = control ? (a - b) : (a + b);
            3'b001:  alu_res = a << shamt;
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, (a < b)};
            3'b100:  alu_res = a ^ b;
            3'b101:  alu_res = control ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
            3'b110:  alu_res = a | b;
            default: alu_res = a & b;
        endcase
    end

    // Operand signedness: divides are signed unless funct3[0]; MULH signs both, MULHSU only a.
    always_comb begin
        sa    = operation[2] ? !operation[0] : (operation == 3'b001 || operation == 3'b010);
        sb    = operation[2] ? !operation[0] : (operation == 3'b001);
        a_neg = sa && a[XLEN-1];
        b_neg = sb && b[XLEN-1];
        a_mag = a_neg ? (-a) : a;
        b_mag = b_neg ? (-b) : b;
    end

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
        mul_next  = {mul_sum, acc_reg[XLEN-1:1]};
        div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd_reg});
        div_rem   = div_ge ? (div_shift[XLEN-1:0] - opnd_reg) : div_shift[XLEN-1:0];
        div_next  = {div_rem, acc_reg[XLEN-2:0], div_ge};
        step_next = op_reg[2] ? div_next : mul_next;
    end

    // Sign fix-up on the final iteration's value so the result lands on the same edge.
    always_comb begin
        prod    = flip_reg ? (-step_next) : step_next;
        quo_fix = divz_reg ? '1 : (flip_reg ? (-step_next[XLEN-1:0]) : step_next[XLEN-1:0]);
        rem_fix = rem_neg_reg ? (-step_next[2*XLEN-1:XLEN]) : step_next[2*XLEN-1:XLEN];
        if (op_reg[2])
            fix_res = op_reg[1] ? rem_fix : quo_fix;
        else
            fix_res = (op_reg[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = muldiv ? RUN : DONE;
            RUN:  if (last_iter) state_next = DONE;
            DONE: if (out_ready) state_next = accept ? (muldiv ? RUN : DONE) : IDLE;
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            result_reg  <= '0;
            op_reg      <= '0;
            opnd_reg    <= '0;
            acc_reg     <= '0;
            flip_reg    <= 1'b0;
            rem_neg_reg <= 1'b0;
            divz_reg    <= 1'b0;
        end else if (accept) begin
            cnt_reg <= '0;
            if (!muldiv) begin
                result_reg <= alu_res;
            end else begin
                op_reg      <= operation;
                opnd_reg    <= operation[2] ? b_mag : a_mag;
                acc_reg     <= {{XLEN{1'b0}}, (operation[2] ? a_mag : b_mag)};
                flip_reg    <= a_neg ^ b_neg;
                rem_neg_reg <= a_neg;
                divz_reg    <= (b == '0);
            end
        end else if ((state_reg == RUN) && !flush) begin
            acc_reg <= step_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (last_iter)
                result_reg <= fix_res;
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: a 32-bit and a 64-bit instance, directed vectors,
// per-transaction result/latency checks plus backpressure, flush and async reset.
module tb_alu_mdu;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        iv[2], ordy[2], fl[2], ctl[2], md[2];
    logic [2:0]  opv[2];
    logic [63:0] av[2], bv[2];
    logic        ir[2], ov[2], zr[2], ng[2];
    logic [31:0] res32;
    logic [63:0] res64;

    int errors = 0;
    int checks = 0;
    int last_wait;

    typedef struct {
        int          unit;
        logic [63:0] exp;
        int          lat;
        longint      t_acc;
        bit [95:0]   name;
    } exp_t;
    exp_t q[$];

    alu_mdu #(.XLEN(32)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[0][31:0]), .b(bv[0][31:0]), .operation(opv[0]), .control(ctl[0]),
        .muldiv(md[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .result(res32),
        .zero(zr[0]), .neg(ng[0])
    );

    alu_mdu #(.XLEN(64)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[1]), .b(bv[1]), .operation(opv[1]), .control(ctl[1]),
        .muldiv(md[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .result(res64),
        .zero(zr[1]), .neg(ng[1])
    );

    function automatic logic [63:0] get_res(input int u);
        return (u == 0) ? {32'h0, res32} : res64;
    endfunction

    task automatic chk(input bit [95:0] name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %0s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_check(input int u);
        exp_t        e;
        logic [63:0] r;
        logic        n;
        longint      lat;
        r = get_res(u);
        if (q.size() == 0 || q[0].unit != u) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output u%0d: got result %h with no pending op", u, r);
            return;
        end
        e = q.pop_front();
        n = (u == 0) ? e.exp[31] : e.exp[63];
        checks++;
        if (r !== e.exp || zr[u] !== (e.exp == 64'h0) || ng[u] !== n) begin
            errors++;
            $display("FAIL %0s u%0d: got result=%h zero=%b neg=%b expected result=%h zero=%b neg=%b",
                     e.name, u, r, zr[u], ng[u], e.exp, (e.exp == 64'h0), n);
        end else begin
            $display("txn %0s u%0d result=%h", e.name, u, r);
        end
        if (e.lat != 0) begin
            lat = ($time + 5 - e.t_acc) / 10;
            checks++;
            if (lat != longint'(e.lat)) begin
                errors++;
                $display("FAIL %0s_latency u%0d: got %0d cycles expected %0d", e.name, u, lat, e.lat);
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n && ov[0] && ordy[0]) pop_check(0);
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && ov[1] && ordy[1]) pop_check(1);
    end

    task automatic issue(input int u, input logic m, input logic [2:0] op, input logic c,
                         input logic [63:0] x, input logic [63:0] y, input logic [63:0] exp,
                         input int lat, input bit push, input bit [95:0] name);
        exp_t e;
        iv[u] = 1'b1; md[u] = m; opv[u] = op; ctl[u] = c; av[u] = x; bv[u] = y;
        last_wait = 0;
        do begin
            @(negedge clk);
            last_wait++;
        end while (!ir[u] && last_wait < 200);
        if (!ir[u]) begin
            checks++;
            errors++;
            $display("FAIL %0s_accept u%0d: in_ready never rose", name, u);
            iv[u] = 1'b0;
            return;
        end
        if (push) begin
            e.unit = u; e.exp = exp; e.lat = lat; e.t_acc = $time + 5; e.name = name;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        iv[u] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic wait_ov(input int u);
        int n = 0;
        while (!ov[u] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ov_wait", 64'(ov[u]), 64'h1);
    endtask

    logic [2:0]  b_op[10]  = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    logic        b_ctl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] b_exp[10] = '{32'hFFFFFFCC, 32'h00000014, 32'hFFFFFF00, 32'h1, 32'h0,
                               32'hFFFFFFD4, 32'hFFFFFFFF, 32'h0FFFFFFF, 32'hFFFFFFF4, 32'h20};

    initial begin
        for (int u = 0; u < 2; u++) begin
            iv[u] = 0; ordy[u] = 1; fl[u] = 0; ctl[u] = 0; md[u] = 0;
            opv[u] = 0; av[u] = 0; bv[u] = 0;
        end
        #1 rst_n = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rst_out_valid", 64'(ov[u]), 64'h0);
            chk("rst_in_ready", 64'(ir[u]), 64'h1);
            chk("rst_result", get_res(u), 64'h0);
            chk("rst_zero", 64'(zr[u]), 64'h1);
            chk("rst_neg", 64'(ng[u]), 64'h0);
        end
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // base sweep, back-to-back with out_ready high
        for (int i = 0; i < 10; i++) begin
            issue(0, 1'b0, b_op[i], b_ctl[i], 64'hFFFFFFF0, 64'h24, {32'h0, b_exp[i]}, 1, 1'b1, "base");
            if (i > 0) chk("stream_accept", 64'(last_wait), 64'h1);
        end
        drain();

        issue(0, 1'b1, 3'b001, 1'b0, 64'h80000000, 64'hFFFFFFFF, 64'h0, 33, 1'b1, "mulh");
        issue(0, 1'b1, 3'b010, 1'b0, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 33, 1'b1, "mulhsu");
        issue(0, 1'b1, 3'b011, 1'b0, 64'h80000000, 64'hFFFFFFFF, 64'h7FFFFFFF, 33, 1'b1, "mulhu");
        issue(0, 1'b1, 3'b000, 1'b0, 64'hFFFFFFFD, 64'h5, 64'hFFFFFFF1, 33, 1'b1, "mul");
        drain();

        issue(0, 1'b1, 3'b100, 1'b0, 64'h7, 64'h0, 64'hFFFFFFFF, 33, 1'b1, "div_by0");
        issue(0, 1'b1, 3'b111, 1'b0, 64'h7, 64'h0, 64'h7, 33, 1'b1, "remu_by0");
        issue(0, 1'b1, 3'b100, 1'b0, 64'hFFFFFFF9, 64'h0, 64'hFFFFFFFF, 33, 1'b1, "divneg_by0");
        issue(0, 1'b1, 3'b110, 1'b0, 64'hFFFFFFF9, 64'h0, 64'hFFFFFFF9, 33, 1'b1, "remneg_by0");
        issue(0, 1'b1, 3'b100, 1'b0, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 33, 1'b1, "div_ovf");
        issue(0, 1'b1, 3'b110, 1'b0, 64'h80000000, 64'hFFFFFFFF, 64'h0, 33, 1'b1, "rem_ovf");
        issue(0, 1'b1, 3'b100, 1'b0, 64'hFFFFFFF9, 64'h2, 64'hFFFFFFFD, 33, 1'b1, "div_m7_2");
        issue(0, 1'b1, 3'b110, 1'b0, 64'hFFFFFFF9, 64'h2, 64'hFFFFFFFF, 33, 1'b1, "rem_m7_2");
        issue(0, 1'b1, 3'b101, 1'b0, 64'hFFFFFFF9, 64'h2, 64'h7FFFFFFC, 33, 1'b1, "divu");
        issue(0, 1'b1, 3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 33, 1'b1, "remu");
        drain();

        // backpressure: result held, then a new op accepted as out_ready rises
        ordy[0] = 1'b0;
        issue(0, 1'b1, 3'b000, 1'b0, 64'd3, 64'd5, 64'd15, 0, 1'b1, "mul_bp");
        wait_ov(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_result", get_res(0), 64'd15);
            chk("bp_in_ready", 64'(ir[0]), 64'h0);
            chk("bp_out_valid", 64'(ov[0]), 64'h1);
        end
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        issue(0, 1'b0, 3'b000, 1'b0, 64'd1, 64'd2, 64'd3, 1, 1'b1, "add_after_bp");
        chk("bp_same_cycle_accept", 64'(last_wait), 64'h1);
        drain();

        // flush at cycle 10 of a divide
        issue(0, 1'b1, 3'b100, 1'b0, 64'd100, 64'd7, 64'd0, 0, 1'b0, "div_flushed");
        repeat (9) @(posedge clk);
        #1 fl[0] = 1'b1;
        @(posedge clk);
        #1 fl[0] = 1'b0;
        chk("flush_out_valid", 64'(ov[0]), 64'h0);
        chk("flush_idle", 64'(ir[0]), 64'h1);
        repeat (40) @(posedge clk);
        #1 chk("flush_no_late_valid", 64'(ov[0]), 64'h0);
        issue(0, 1'b0, 3'b000, 1'b0, 64'd1, 64'd2, 64'd3, 1, 1'b1, "add_after_flush");
        drain();

        // flush beats a simultaneous in_valid
        iv[0] = 1'b1; md[0] = 1'b0; opv[0] = 3'b000; ctl[0] = 1'b0; av[0] = 64'd5; bv[0] = 64'd5;
        fl[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        fl[0] = 1'b0;
        chk("flush_blocks_accept", 64'(ov[0]), 64'h0);

        // flush in DONE under backpressure: valid drops, result holds
        ordy[0] = 1'b0;
        issue(0, 1'b1, 3'b000, 1'b0, 64'd3, 64'd5, 64'd0, 0, 1'b0, "mul_flushed");
        wait_ov(0);
        fl[0] = 1'b1;
        @(posedge clk);
        #1;
        fl[0] = 1'b0;
        chk("flush_done_valid", 64'(ov[0]), 64'h0);
        chk("flush_result_hold", get_res(0), 64'd15);
        ordy[0] = 1'b1;

        // asynchronous reset mid-RUN, dropped between clock edges
        issue(0, 1'b1, 3'b100, 1'b0, 64'd100, 64'd7, 64'd0, 0, 1'b0, "div_reset");
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_result", get_res(0), 64'h0);
        chk("arst_zero", 64'(zr[0]), 64'h1);
        chk("arst_in_ready", 64'(ir[0]), 64'h1);
        chk("arst_out_valid", 64'(ov[0]), 64'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1 chk("arst_no_stale_valid", 64'(ov[0]), 64'h0);

        // XLEN=64 instance
        issue(1, 1'b0, 3'b000, 1'b1, 64'hFFFFFFFFFFFFFFF0, 64'h24, 64'hFFFFFFFFFFFFFFCC, 1, 1'b1, "sub64");
        issue(1, 1'b0, 3'b101, 1'b1, 64'hFFFFFFFFFFFFFFF0, 64'h24, 64'hFFFFFFFFFFFFFFFF, 1, 1'b1, "sra64");
        issue(1, 1'b0, 3'b001, 1'b0, 64'h1, 64'd40, 64'h0000010000000000, 1, 1'b1, "sll64");
        issue(1, 1'b1, 3'b000, 1'b0, 64'h100000000, 64'h100000000, 64'h0, 65, 1'b1, "mul64");
        issue(1, 1'b1, 3'b011, 1'b0, 64'h100000000, 64'h100000000, 64'h1, 65, 1'b1, "mulhu64");
        issue(1, 1'b1, 3'b001, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h0, 65, 1'b1, "mulh64");
        issue(1, 1'b1, 3'b100, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'h2, 64'hFFFFFFFFFFFFFFFD, 65, 1'b1, "div64");
        issue(1, 1'b1, 3'b110, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'h2, 64'hFFFFFFFFFFFFFFFF, 65, 1'b1, "rem64");
        issue(1, 1'b1, 3'b100, 1'b0, 64'h7, 64'h0, 64'hFFFFFFFFFFFFFFFF, 65, 1'b1, "div64_by0");
        issue(1, 1'b1, 3'b100, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
              64'h8000000000000000, 65, 1'b1, "div64_ovf");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised integer execute unit: the RV32I/RV64I register-register ALU operations plus the M-extension multiply/divide set, behind a valid/ready handshake. Base ALU operations complete in one cycle. Multiply and divide run iteratively over a fixed XLEN cycles. The block sits in the execute stage, and the pipeline stalls on `in_ready`/`out_valid`.

## Interface
- `XLEN`, default 32: datapath width. Legal values are 32 and 64.
- `SHW`, default $clog2(XLEN): shift-amount width, derived. Do not override.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort of any accepted or in-flight operation.
- `in_valid`  in  1  operands and opcode are valid.
- `in_ready`  out  1  block can accept this cycle.
- `a`, `b`  in  XLEN  operands (rs1, rs2 or imm).
- `operation`  in  3  funct3.
- `control`  in  1  instr bit 30: sub/sra select. Ignored when `muldiv`=1.
- `muldiv`  in  1  instr funct7 bit 0. Selects the M-extension decode of `operation`.
- `out_valid`  out  1  `result` holds a finished value.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  XLEN  registered result.
- `zero`  out  1  `result` == 0.
- `neg`  out  1  `result[XLEN-1]`.

## Operation
- Base decode (`muldiv`=0):
  - 000: add, or sub when `control`=1.
  - 001: sll.
  - 010: slt (signed compare, computed internally).
  - 011: sltu.
  - 100: xor.
  - 101: srl, or sra when `control`=1.
  - 110: or.
  - 111: and.
  - Shift amount is `b[SHW-1:0]`. Upper bits of `b` are ignored.
  - slt/sltu return a value zero-extended to XLEN.
- M decode (`muldiv`=1):
  - 000 MUL: low XLEN bits of the product.
  - 001 MULH: signed×signed, high half.
  - 010 MULHSU: signed `a` × unsigned `b`, high half.
  - 011 MULHU: unsigned×unsigned, high half.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Multiply: radix-2 shift-add on operand magnitudes with a 2·XLEN accumulator. Negate the product at the end when the operand signs differ (signed forms only).
- Divide: radix-2 restoring on magnitudes.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Divide special cases (no trap):
  - Divide by zero: quotient = all ones; remainder = `a`.
  - Signed overflow (a = −2^(XLEN−1), b = −1): quotient = `a`; remainder = 0.
  - Special cases still take the full XLEN iterations, so latency is data-independent.
- States:
  - IDLE:
    - Accept on `in_valid`&`in_ready`.
    - Base op: result computed combinationally and registered; go to DONE.
    - M op: latch operands; counter ← 0; go to RUN.
  - RUN:
    - One iteration per cycle.
    - After iteration XLEN−1: apply sign fix-up, register the result, go to DONE.
  - DONE:
    - `out_valid`=1; `result`, `zero` and `neg` are stable.
    - On `out_ready`: go to IDLE, or directly accept a new op if `in_valid` (see in_ready).
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`). This is combinational from state and `out_ready`.
- `flush`:
  - In any state, next state = IDLE, and any op presented in the same cycle is not accepted.
  - `out_valid` is 0 from the next cycle.
  - `result` holds its last value.
- Reset (asynchronous, any state, including mid-RUN):
  - State = IDLE; counter = 0; `result` = 0.
  - `out_valid` = 0, `zero` = 1, `neg` = 0.
  - `in_ready` = 1 (IDLE).

## Timing
- Acceptance edge = cycle 0.
- Base op: `out_valid` is high in cycle 1.
- M op: RUN occupies cycles 1..XLEN, and `out_valid` is high in cycle XLEN+1.
  - XLEN=32: 33 cycles.
  - XLEN=64: 65 cycles.
- Back-to-back base ops with `out_ready` held at 1 sustain one result per cycle.
- `out_valid` stays high until consumed. `result` must not change while `out_valid`=1 and `out_ready`=0.
- `flush` has priority over `in_valid`. `rst_n` has priority over everything.
- Inputs are sampled only at the acceptance edge. Operand changes during RUN have no effect.

## Test plan
- Base sweep, XLEN=32, `out_ready`=1: a=0xFFFFFFF0, b=0x00000024.
  - sub → 0xFFFFFFCC.
  - sra → 0xFFFFFFFF (shamt 4).
  - slt → 1; sltu → 0.
  - Each result arrives 1 cycle after acceptance, and the results stream one per cycle.
- MULH/MULHSU/MULHU with a=0x80000000, b=0xFFFFFFFF:
  - MULH → 0x00000000.
  - MULHSU → 0x80000000.
  - MULHU → 0x7FFFFFFF.
  - `out_valid` arrives exactly 33 cycles after acceptance.
- Divide corners:
  - DIV 7/0 → 0xFFFFFFFF.
  - REMU 7/0 → 7.
  - DIV 0x80000000 / −1 → 0x80000000.
  - REM of the same → 0 with `zero`=1.
  - DIV −7/2 → −3; REM → −1.
  - Every case takes 33 cycles.
- Backpressure: hold `out_ready`=0 for 5 cycles after a MUL 3×5.
  - `result`=15 is held stable and `in_ready`=0 throughout.
  - When `out_ready` rises together with `in_valid`, the new op is accepted that cycle.
- Flush mid-RUN: assert `flush` at cycle 10 of a DIV.
  - Cycle 11: state IDLE, `out_valid`=0.
  - The next accepted ADD 1+2 returns 3 after 1 cycle.
- Async reset mid-RUN: drop `rst_n` off a clock edge.
  - Outputs go to reset values immediately (`result`=0, `zero`=1, `in_ready`=1).
  - No stale `out_valid` appears after release.
  - Repeat the test sweep with XLEN=64 (MUL 2^32×2^32 → 0 low, MULHU → 1).
